// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder slice.
//   DATA_W   : data word width (32 bits)
//   CNT_W    : width of the access-latency counter (covers LATENCY up to 15)
//   state_e  : responder FSM encoding (IDLE / WAIT / RESP)
//   clog2()  : index width needed to address a given number of words
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Smallest r with (1 << r) >= value; bounded loop so it elaborates as a constant.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the CPU (master) and the data-memory
// responder (slave).
//   req_valid_i / req_ready_o : request handshake, transfer when both high
//   req_write_i               : 1 = store, 0 = load
//   req_addr_i                : byte address
//   req_wdata_i               : store data
//   resp_valid_o              : one-cycle completion pulse
//   resp_rdata_o              : load data (0 for stores and faulted loads)
//   resp_err_o                : access faulted
// Signal names carry the responder's point of view so they match the
// responder's documented port list.
interface dmem_responder_if
    import dmem_pkg::*;
    ();

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [31:0]       req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_rdata_o;
    logic              resp_err_o;

    modport slave (
        input  req_valid_i,
        input  req_write_i,
        input  req_addr_i,
        input  req_wdata_i,
        output req_ready_o,
        output resp_valid_o,
        output resp_rdata_o,
        output resp_err_o
    );

    modport master (
        output req_valid_i,
        output req_write_i,
        output req_addr_i,
        output req_wdata_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  resp_rdata_o,
        input  resp_err_o
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
//   clk   : clock
//   clr_n : synchronous active-low clear of every word (priority over write)
//   wr_en : write enable, word idx takes wdata at the rising edge
//   idx   : word index, shared by read and write
//   wdata : write data
//   rdata : combinational read of word idx
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    localparam int IDX_W      = clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH_WORDS];

    // Storage update: clear wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en) begin
            mem_r[idx] <= wdata;
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline's MEM stage: word-addressed memory
// behind a valid/ready request handshake with a fixed access latency.
//   clk_i : clock, all state on the rising edge
//   rst_i : synchronous active-low reset (clears FSM, outputs and memory)
//   bus   : dmem_responder_if.slave (request handshake + response)
// Parameters: DEPTH_WORDS (power of two, >= 4), LATENCY (1..15 cycles from
// accept to resp_valid_o).
// Optional feature macro DMEM_ERR_EN: when defined, misaligned or
// out-of-range addresses fault (no write, load data 0, resp_err_o=1);
// when undefined the index simply wraps and resp_err_o stays 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int IDX_W = clog2(DEPTH_WORDS);
    // WAIT counts down from LATENCY-2 so RESP is entered LATENCY-1 edges after accept.
    localparam logic [CNT_W-1:0] WAIT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};

    state_e            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              wr_r;
    logic [31:0]       addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              ready_r;
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              resp_err_r;

    logic              accept_s;
    logic              enter_resp_s;
    logic              acc_write_s;
    logic [31:0]       acc_addr_s;
    logic [DATA_W-1:0] acc_wdata_s;
    logic              fault_s;
    logic              arr_we_s;
    logic [DATA_W-1:0] arr_rdata_s;
    logic [DATA_W-1:0] load_data_s;

    assign accept_s = bus.req_valid_i & ready_r;

    // Cycle in which the array is accessed (the transition into RESP).
    always_comb begin
        enter_resp_s = 1'b0;
        if ((state_r == IDLE) && accept_s && (LATENCY == 1)) begin
            enter_resp_s = 1'b1;
        end else if ((state_r == WAIT) && (cnt_r == {CNT_W{1'b0}})) begin
            enter_resp_s = 1'b1;
        end else begin
            enter_resp_s = 1'b0;
        end
    end

    // With LATENCY==1 the access happens on the accept edge, before the
    // request latch holds anything, so take the live bus in IDLE.
    always_comb begin
        acc_write_s = wr_r;
        acc_addr_s  = addr_r;
        acc_wdata_s = wdata_r;
        if (state_r == IDLE) begin
            acc_write_s = bus.req_write_i;
            acc_addr_s  = bus.req_addr_i;
            acc_wdata_s = bus.req_wdata_i;
        end else begin
            acc_write_s = wr_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
    end

`ifdef DMEM_ERR_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    // Fault on misalignment or an address past the end of the array.
    always_comb begin
        fault_s = 1'b0;
        if (acc_addr_s[1:0] != 2'b00) begin
            fault_s = 1'b1;
        end else if ({1'b0, acc_addr_s} >= ADDR_LIMIT) begin
            fault_s = 1'b1;
        end else begin
            fault_s = 1'b0;
        end
    end
`else
    // Byte offset and bits above the index are ignored; the index wraps.
    logic addr_unused_s;
    assign addr_unused_s = ^{acc_addr_s[31:IDX_W+2], acc_addr_s[1:0]};
    assign fault_s       = 1'b0;
`endif

    assign arr_we_s = enter_resp_s & acc_write_s & ~fault_s;

    // Stores and faulted loads return zero.
    always_comb begin
        load_data_s = {DATA_W{1'b0}};
        if (acc_write_s || fault_s) begin
            load_data_s = {DATA_W{1'b0}};
        end else begin
            load_data_s = arr_rdata_s;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk_i),
        .clr_n (rst_i),
        .wr_en (arr_we_s),
        .idx   (acc_addr_s[IDX_W+1:2]),
        .wdata (acc_wdata_s),
        .rdata (arr_rdata_s)
    );

    // Responder FSM, latency counter, request latch and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            wr_r         <= 1'b0;
            addr_r       <= 32'd0;
            wdata_r      <= {DATA_W{1'b0}};
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {DATA_W{1'b0}};
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        wr_r    <= bus.req_write_i;
                        addr_r  <= bus.req_addr_i;
                        wdata_r <= bus.req_wdata_i;
                        ready_r <= 1'b0;
                        if (enter_resp_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_rdata_r <= load_data_s;
                            resp_err_r   <= fault_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (enter_resp_s) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= load_data_s;
                        resp_err_r   <= fault_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= {DATA_W{1'b0}};
                    resp_err_r   <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_rdata_r <= {DATA_W{1'b0}};
                    resp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o  = ready_r;
    assign bus.resp_valid_o = resp_valid_r;
    assign bus.resp_rdata_o = resp_rdata_r;
    assign bus.resp_err_o   = resp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance A uses LATENCY=2, instance B
// LATENCY=1, both DEPTH_WORDS=128. A select bit routes the shared request
// drivers to one instance and its response back to the checks.
module tb_dmem_responder;

    logic        clk;
    logic        rst_i;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    dmem_responder_if ifa ();
    dmem_responder_if ifb ();

    assign ifa.req_valid_i = req_valid & ~sel;
    assign ifa.req_write_i = req_write;
    assign ifa.req_addr_i  = req_addr;
    assign ifa.req_wdata_i = req_wdata;
    assign ifb.req_valid_i = req_valid & sel;
    assign ifb.req_write_i = req_write;
    assign ifb.req_addr_i  = req_addr;
    assign ifb.req_wdata_i = req_wdata;

    logic        obs_ready;
    logic        obs_rvalid;
    logic [31:0] obs_rdata;
    logic        obs_err;
    assign obs_ready  = sel ? ifb.req_ready_o  : ifa.req_ready_o;
    assign obs_rvalid = sel ? ifb.resp_valid_o : ifa.resp_valid_o;
    assign obs_rdata  = sel ? ifb.resp_rdata_o : ifa.resp_rdata_o;
    assign obs_err    = sel ? ifb.resp_err_o   : ifa.resp_err_o;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut_a (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (ifa.slave)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) dut_b (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One request on the selected instance; checks handshake timing and the
    // pulse shape. bp keeps req_valid high and changes the store data while
    // the responder is busy, which must be ignored.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input bit bp,
                        output logic [31:0] rd, output logic er, output int rc);
        int lat;
        bit got;
        lat = sel ? 1 : 2;
        got = 1'b0;
        rd  = 32'd0;
        er  = 1'b0;
        rc  = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        for (int n = 0; n < 20 && !obs_ready; n++) @(negedge clk);
        chk("accept_ready", 32'(obs_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (bp) req_wdata = d + 32'd1;
                else    req_valid = 1'b0;
            end
            chk("busy_ready", 32'(obs_ready), 32'd0);
            if (obs_rvalid) begin
                got = 1'b1;
                chk("latency", 32'(k), 32'(lat));
                rd = obs_rdata;
                er = obs_err;
                rc = cyc;
                req_valid = 1'b0;
            end
        end
        chk("resp_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk("pulse_end", 32'(obs_rvalid), 32'd0);
        chk("rdata_clear", obs_rdata, 32'd0);
        chk("err_clear", 32'(obs_err), 32'd0);
        chk("ready_back", 32'(obs_ready), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          rc1;
    int          rc2;

    initial begin
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        rst_i     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;

        // Reset state and a load from cleared memory.
        chk("rst_ready", 32'(obs_ready), 32'd1);
        chk("rst_rvalid", 32'(obs_rvalid), 32'd0);
        chk("rst_rdata", obs_rdata, 32'd0);
        chk("rst_err", 32'(obs_err), 32'd0);
        xfer(1'b0, 32'h10, 32'd0, 1'b0, rd, er, rc1);
        chk("rst_load", rd, 32'd0);

        // LATENCY=2 store then load.
        xfer(1'b1, 32'h04, 32'hDEADBEEF, 1'b0, rd, er, rc1);
        chk("st_rdata_zero", rd, 32'd0);
        chk("st_err", 32'(er), 32'd0);
        xfer(1'b0, 32'h04, 32'd0, 1'b0, rd, er, rc1);
        chk("ld_deadbeef", rd, 32'hDEADBEEF);

        // Backpressure: busy-time data change must not be written.
        xfer(1'b1, 32'h08, 32'h1, 1'b1, rd, er, rc1);
        xfer(1'b0, 32'h08, 32'd0, 1'b0, rd, er, rc1);
        chk("bp_load", rd, 32'h1);

        // LATENCY=1 back-to-back on instance B.
        sel = 1'b1;
        @(negedge clk);
        xfer(1'b1, 32'h0C, 32'hA5A5A5A5, 1'b0, rd, er, rc1);
        xfer(1'b0, 32'h0C, 32'd0, 1'b0, rd, er, rc2);
        chk("b2b_spacing", 32'(rc2 - rc1), 32'd2);
        chk("b2b_data", rd, 32'hA5A5A5A5);

        // Reset in the middle of a store on instance A.
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h14;
        req_wdata = 32'h55;
        for (int n = 0; n < 20 && !obs_ready; n++) @(negedge clk);
        chk("mid_accept_ready", 32'(obs_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_i     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mid_no_resp", 32'(obs_rvalid), 32'd0);
            @(negedge clk);
        end
        rst_i = 1'b1;
        chk("mid_no_resp_end", 32'(obs_rvalid), 32'd0);
        chk("mid_ready", 32'(obs_ready), 32'd1);
        xfer(1'b0, 32'h14, 32'd0, 1'b0, rd, er, rc1);
        chk("mid_load_zero", rd, 32'd0);
        xfer(1'b0, 32'h04, 32'd0, 1'b0, rd, er, rc1);
        chk("mid_cleared", rd, 32'd0);

`ifdef DMEM_ERR_EN
        xfer(1'b0, 32'h02, 32'd0, 1'b0, rd, er, rc1);
        chk("err_misalign", 32'(er), 32'd1);
        chk("err_misalign_data", rd, 32'd0);
        xfer(1'b1, 32'h200, 32'h9, 1'b0, rd, er, rc1);
        chk("err_range", 32'(er), 32'd1);
        xfer(1'b0, 32'h00, 32'd0, 1'b0, rd, er, rc1);
        chk("err_no_write", rd, 32'd0);
        chk("err_ok_load", 32'(er), 32'd0);
`else
        xfer(1'b1, 32'h206, 32'h7, 1'b0, rd, er, rc1);
        chk("wrap_st_err", 32'(er), 32'd0);
        xfer(1'b0, 32'h04, 32'd0, 1'b0, rd, er, rc1);
        chk("wrap_load", rd, 32'h7);
        chk("wrap_err", 32'(er), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
